// File: rtl/arp_ctrl.sv
// ARP sequencer: resolves the MAC of a target IP with timeout/retry/refresh,
// answers ARP requests to us, and arbitrates reply/request onto one tx channel.
module arp_ctrl #(
    parameter logic [23:0] TMO_CYC   = 24'd12_500_000,
    parameter logic [2:0]  MAX_RETRY = 3'd3,
    parameter logic [31:0] AGE_CYC   = 32'd1_250_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_target_ip,
    input  logic        i_resolve,
    input  logic [1:0]  i_arp_operation,
    input  logic [47:0] i_arp_sender_mac,
    input  logic [31:0] i_arp_sender_ip,
    output logic        o_send_vld,
    input  logic        i_send_rdy,
    output logic [1:0]  o_send_op,
    output logic [47:0] o_send_tha,
    output logic [31:0] o_send_tpa,
    output logic        o_resolved,
    output logic [47:0] o_target_mac,
    output logic        o_fail,
    output logic        o_busy
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StResolved, StFail} state_e;

    state_e      state_q, state_d;
    logic [31:0] tgt_ip_q, tgt_ip_d;
    logic [2:0]  retry_q, retry_d;
    logic [23:0] timer_q, timer_d;
    logic [31:0] age_q, age_d;
    logic        req_pend_q, req_pend_d;
    logic        stale_q, stale_d;
    logic        rep_pend_q, rep_pend_d;
    logic [47:0] rep_mac_q, rep_mac_d;
    logic [31:0] rep_ip_q, rep_ip_d;
    logic        send_vld_q, send_vld_d;
    logic [1:0]  send_op_q, send_op_d;
    logic [47:0] send_tha_q, send_tha_d;
    logic [31:0] send_tpa_q, send_tpa_d;
    logic        resolved_q, resolved_d;
    logic [47:0] target_mac_q, target_mac_d;
    logic        fail_q, fail_d;

    logic       req_set, req_acc, ip_hit, rep_load, req_load;
    logic [2:0] retry_inc;

    always_comb begin
        state_d      = state_q;
        tgt_ip_d     = tgt_ip_q;
        retry_d      = retry_q;
        timer_d      = timer_q;
        age_d        = age_q;
        stale_d      = stale_q;
        resolved_d   = resolved_q;
        target_mac_d = target_mac_q;
        fail_d       = fail_q;
        req_set      = 1'b0;
        retry_inc    = retry_q + 3'd1;
        req_acc      = send_vld_q & i_send_rdy & (send_op_q == 2'd1);
        ip_hit       = (i_arp_sender_ip == tgt_ip_q);

        // A request that was in flight at restart time completes without advancing the FSM
        if (req_acc) stale_d = 1'b0;

        if (i_resolve) begin
            tgt_ip_d   = i_target_ip;
            retry_d    = 3'd0;
            resolved_d = 1'b0;
            fail_d     = 1'b0;
            state_d    = StReq;
            req_set    = 1'b1;
            stale_d    = send_vld_q & (send_op_q == 2'd1) & ~i_send_rdy;
        end else begin
            if ((i_arp_operation == 2'd1 || i_arp_operation == 2'd2) && ip_hit
                && state_q != StIdle && state_q != StFail) begin
                target_mac_d = i_arp_sender_mac;
            end
            case (state_q)
                StIdle, StFail: ;
                StReq: begin
                    if (req_acc && !stale_q) begin
                        state_d = StWait;
                        timer_d = TMO_CYC - 24'd1;
                    end
                end
                StWait: begin
                    if (i_arp_operation == 2'd2 && ip_hit) begin
                        resolved_d = 1'b1;
                        state_d    = StResolved;
                        age_d      = AGE_CYC - 32'd1;
                    end else if (timer_q == 24'd0) begin
                        retry_d = retry_inc;
                        if (retry_inc == MAX_RETRY) begin
                            state_d    = StFail;
                            fail_d     = 1'b1;
                            resolved_d = 1'b0;
                        end else begin
                            state_d = StReq;
                            req_set = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q - 24'd1;
                    end
                end
                StResolved: begin
                    if (age_q == 32'd0) begin
                        state_d = StReq;
                        retry_d = 3'd0;
                        req_set = 1'b1;
                    end else begin
                        age_d = age_q - 32'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Tx arbiter: loads only while the channel is idle; a pending reply beats a request
    always_comb begin
        send_vld_d = send_vld_q;
        send_op_d  = send_op_q;
        send_tha_d = send_tha_q;
        send_tpa_d = send_tpa_q;
        rep_pend_d = rep_pend_q;
        rep_mac_d  = rep_mac_q;
        rep_ip_d   = rep_ip_q;
        rep_load   = ~send_vld_q & rep_pend_q;
        req_load   = ~send_vld_q & ~rep_pend_q & (req_pend_q | req_set);
        req_pend_d = (req_pend_q | req_set) & ~req_load;

        if (send_vld_q && i_send_rdy) send_vld_d = 1'b0;

        if (rep_load) begin
            send_vld_d = 1'b1;
            send_op_d  = 2'd2;
            send_tha_d = rep_mac_q;
            send_tpa_d = rep_ip_q;
            rep_pend_d = 1'b0;
            rep_mac_d  = 48'd0;
            rep_ip_d   = 32'd0;
        end else if (req_load) begin
            send_vld_d = 1'b1;
            send_op_d  = 2'd1;
            send_tha_d = 48'd0;
            send_tpa_d = tgt_ip_d;
        end

        if (i_arp_operation == 2'd1) begin
            rep_pend_d = 1'b1;
            rep_mac_d  = i_arp_sender_mac;
            rep_ip_d   = i_arp_sender_ip;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            tgt_ip_q     <= 32'd0;
            retry_q      <= 3'd0;
            timer_q      <= 24'd0;
            age_q        <= 32'd0;
            req_pend_q   <= 1'b0;
            stale_q      <= 1'b0;
            rep_pend_q   <= 1'b0;
            rep_mac_q    <= 48'd0;
            rep_ip_q     <= 32'd0;
            send_vld_q   <= 1'b0;
            send_op_q    <= 2'd0;
            send_tha_q   <= 48'd0;
            send_tpa_q   <= 32'd0;
            resolved_q   <= 1'b0;
            target_mac_q <= 48'd0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_ip_q     <= tgt_ip_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            age_q        <= age_d;
            req_pend_q   <= req_pend_d;
            stale_q      <= stale_d;
            rep_pend_q   <= rep_pend_d;
            rep_mac_q    <= rep_mac_d;
            rep_ip_q     <= rep_ip_d;
            send_vld_q   <= send_vld_d;
            send_op_q    <= send_op_d;
            send_tha_q   <= send_tha_d;
            send_tpa_q   <= send_tpa_d;
            resolved_q   <= resolved_d;
            target_mac_q <= target_mac_d;
            fail_q       <= fail_d;
        end
    end

    assign o_send_vld   = send_vld_q;
    assign o_send_op    = send_op_q;
    assign o_send_tha   = send_tha_q;
    assign o_send_tpa   = send_tpa_q;
    assign o_resolved   = resolved_q;
    assign o_target_mac = target_mac_q;
    assign o_fail       = fail_q;
    assign o_busy       = (state_q == StReq) || (state_q == StWait);

endmodule

// File: tb/tb_arp_ctrl.sv
// Directed bench for arp_ctrl with short timers (TMO 16, retry 3, age 64).
module tb_arp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_target_ip;
    logic        i_resolve;
    logic [1:0]  i_arp_operation;
    logic [47:0] i_arp_sender_mac;
    logic [31:0] i_arp_sender_ip;
    logic        o_send_vld;
    logic        i_send_rdy;
    logic [1:0]  o_send_op;
    logic [47:0] o_send_tha;
    logic [31:0] o_send_tpa;
    logic        o_resolved;
    logic [47:0] o_target_mac;
    logic        o_fail;
    logic        o_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int n;

    arp_ctrl #(
        .TMO_CYC  (24'd16),
        .MAX_RETRY(3'd3),
        .AGE_CYC  (32'd64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_target_ip     (i_target_ip),
        .i_resolve       (i_resolve),
        .i_arp_operation (i_arp_operation),
        .i_arp_sender_mac(i_arp_sender_mac),
        .i_arp_sender_ip (i_arp_sender_ip),
        .o_send_vld      (o_send_vld),
        .i_send_rdy      (i_send_rdy),
        .o_send_op       (o_send_op),
        .o_send_tha      (o_send_tha),
        .o_send_tpa      (o_send_tpa),
        .o_resolved      (o_resolved),
        .o_target_mac    (o_target_mac),
        .o_fail          (o_fail),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept();
        i_send_rdy = 1'b1;
        step(1);
        i_send_rdy = 1'b0;
    endtask

    task automatic rx(input logic [1:0] op, input logic [47:0] mac, input logic [31:0] ip);
        i_arp_operation  = op;
        i_arp_sender_mac = mac;
        i_arp_sender_ip  = ip;
        step(1);
        i_arp_operation  = 2'd0;
    endtask

    // Steps until a request goes out or failure is flagged; returns cycles taken
    task automatic wait_tx(output int cycles);
        cycles = 0;
        while (!(o_send_vld || o_fail) && cycles < 40) begin
            step(1);
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1;
        i_target_ip = '0;
        i_resolve = 1'b0;
        i_arp_operation = 2'd0;
        i_arp_sender_mac = '0;
        i_arp_sender_ip = '0;
        i_send_rdy = 1'b0;
        step(2);
        rst = 1'b0;
        check("rst_vld", o_send_vld, 0);
        check("rst_op", o_send_op, 0);
        check("rst_tha", o_send_tha, 0);
        check("rst_tpa", o_send_tpa, 0);
        check("rst_resolved", o_resolved, 0);
        check("rst_mac", o_target_mac, 0);
        check("rst_fail", o_fail, 0);
        check("rst_busy", o_busy, 0);

        // Basic resolution
        i_target_ip = 32'hC0A80002;
        i_resolve = 1'b1;
        step(1);
        i_resolve = 1'b0;
        check("t1_vld", o_send_vld, 1);
        check("t1_op", o_send_op, 1);
        check("t1_tha", o_send_tha, 0);
        check("t1_tpa", o_send_tpa, 32'hC0A80002);
        check("t1_busy", o_busy, 1);
        accept();
        check("t1_vld_drop", o_send_vld, 0);
        step(10);
        rx(2'd2, 48'h0011223344AA, 32'hC0A80002);
        check("t1_resolved", o_resolved, 1);
        check("t1_mac", o_target_mac, 48'h0011223344AA);
        check("t1_fail", o_fail, 0);
        check("t1_busy_done", o_busy, 0);

        // Refresh after 64 cycles
        step(63);
        check("t5_no_refresh_yet", o_send_vld, 0);
        step(1);
        check("t5_refresh_vld", o_send_vld, 1);
        check("t5_refresh_op", o_send_op, 1);
        check("t5_refresh_tpa", o_send_tpa, 32'hC0A80002);
        check("t5_resolved_held", o_resolved, 1);
        check("t5_busy", o_busy, 1);
        accept();
        step(3);
        check("t5_resolved_wait", o_resolved, 1);
        rx(2'd2, 48'h0011223344BB, 32'hC0A80002);
        check("t5_new_mac", o_target_mac, 48'h0011223344BB);
        check("t5_resolved", o_resolved, 1);
        check("t5_busy_done", o_busy, 0);

        // Three timeouts then failure
        i_target_ip = 32'hC0A80005;
        i_resolve = 1'b1;
        step(1);
        i_resolve = 1'b0;
        check("t2_vld0", o_send_vld, 1);
        check("t2_tpa0", o_send_tpa, 32'hC0A80005);
        check("t2_resolved_clr", o_resolved, 0);
        for (int k = 0; k < 3; k++) begin
            accept();
            wait_tx(n);
            check("t2_gap", n, 16);
            if (k < 2) begin
                check("t2_retry_vld", o_send_vld, 1);
                check("t2_retry_op", o_send_op, 1);
                check("t2_fail_early", o_fail, 0);
            end
        end
        check("t2_fail", o_fail, 1);
        check("t2_no_4th", o_send_vld, 0);
        check("t2_busy", o_busy, 0);
        step(20);
        check("t2_still_quiet", o_send_vld, 0);
        check("t2_fail_hold", o_fail, 1);

        // Wrong-IP reply ignored; match on the timer-0 cycle wins
        i_target_ip = 32'hC0A80002;
        i_resolve = 1'b1;
        step(1);
        i_resolve = 1'b0;
        check("t4_fail_clr", o_fail, 0);
        check("t4_vld", o_send_vld, 1);
        accept();
        step(5);
        rx(2'd2, 48'h0011223344DD, 32'hC0A80003);
        check("t4_wrong_ip_res", o_resolved, 0);
        check("t4_wrong_ip_mac", o_target_mac, 48'h0011223344BB);
        wait_tx(n);
        check("t4_retry_gap", n + 6, 16);
        check("t4_retry_op", o_send_op, 1);
        check("t4_retry_tpa", o_send_tpa, 32'hC0A80002);
        accept();
        step(15);
        rx(2'd2, 48'h0011223344CC, 32'hC0A80002);
        check("t4_edge_resolved", o_resolved, 1);
        check("t4_edge_mac", o_target_mac, 48'h0011223344CC);
        check("t4_edge_fail", o_fail, 0);
        check("t4_edge_busy", o_busy, 0);
        step(3);
        check("t4_no_retry", o_send_vld, 0);

        // Pending reply beats pending request; outputs hold while stalled
        rx(2'd1, 48'hAABBCCDDEEFF, 32'hC0A80009);
        i_target_ip = 32'hC0A80007;
        i_resolve = 1'b1;
        step(1);
        i_resolve = 1'b0;
        check("t3_vld", o_send_vld, 1);
        check("t3_reply_first", o_send_op, 2);
        check("t3_tha", o_send_tha, 48'hAABBCCDDEEFF);
        check("t3_tpa", o_send_tpa, 32'hC0A80009);
        check("t3_busy", o_busy, 1);
        for (int c = 0; c < 20; c++) begin
            step(1);
            check("t6_hold", {o_send_vld, o_send_op, o_send_tha, o_send_tpa},
                  {1'b1, 2'd2, 48'hAABBCCDDEEFF, 32'hC0A80009});
        end
        accept();
        check("t3_idle_gap", o_send_vld, 0);
        step(1);
        check("t3_req_vld", o_send_vld, 1);
        check("t3_req_op", o_send_op, 1);
        check("t3_req_tha", o_send_tha, 0);
        check("t3_req_tpa", o_send_tpa, 32'hC0A80007);

        // Reset during a stalled transfer
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_rst_vld", o_send_vld, 0);
        check("t6_rst_op", o_send_op, 0);
        check("t6_rst_tpa", o_send_tpa, 0);
        check("t6_rst_mac", o_target_mac, 0);
        check("t6_rst_busy", o_busy, 0);
        step(5);
        check("t6_no_pending", o_send_vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
